rect_margin_checker: RTL and testbench

Read-side companion to the rectangle-loop sampler. It snapshots the binary matrix the sampler writes and scans it one row per cycle, computing every row sum and column sum. In capture mode it stores those sums as reference margins; in check mode it compares them against the stored reference. This proves that every checkerboard swap preserved the margins. It sits beside the sampler on the matrix bus and reports pass/fail with a start/done handshake.

---
 rtl/rect_margin_checker_pkg.sv | 32 +++
 rtl/rect_margin_checker_row_popcount.sv | 22 ++
 rtl/rect_margin_checker.sv | 188 ++++++++++++++++++
 tb/tb_rect_margin_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_margin_checker_pkg.sv
// rect_pkg: shared definitions for the rectangle-loop sampler and its
// margin checker.
//   chk_state_t : checker FSM states
//   MODE_*      : scan mode encodings carried on the checker's mode input
//   *_w()       : widths of row-sum, column-sum and total-ones counters
package rect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    COMPARE = 2'd2
  } chk_state_t;

  localparam logic MODE_CAPTURE = 1'b0;
  localparam logic MODE_CHECK   = 1'b1;

  // A row holds at most 'cols' ones.
  function automatic int row_sum_w(input int cols);
    return $clog2(cols + 1);
  endfunction

  // A column holds at most 'rows' ones.
  function automatic int col_sum_w(input int rows);
    return $clog2(rows + 1);
  endfunction

  // The whole matrix holds at most rows*cols ones.
  function automatic int total_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/rect_margin_checker_row_popcount.sv
// rect_row_popcount: purely combinational count of ones in a W-bit vector.
//   i_vec   : input vector
//   o_count : number of set bits in i_vec
module rect_row_popcount
  import rect_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]              i_vec,
  output logic [row_sum_w(W)-1:0]   o_count
);

  localparam int CW = row_sum_w(W);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/rect_margin_checker.sv
// rect_margin_checker: snapshots the sampler's binary matrix, scans it one
// row per cycle to form every row and column sum, and either stores those
// sums as reference margins (capture) or compares them to the stored
// reference (check).
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   start, mode   : scan request (taken only in IDLE) and its mode
//   m_in          : flattened matrix, element [r][c] at bit r*COLS+c
//   busy, done    : busy from acceptance through the done pulse
//   match, no_ref : margins equal reference / check without reference
//   row_mismatch  : per-row sum differs from reference
//   col_mismatch  : per-column sum differs from reference
//   ones_count    : total ones in the snapshot
module rect_margin_checker
  import rect_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             mode,
  input  logic [ROWS*COLS-1:0]             m_in,
  output logic                             busy,
  output logic                             done,
  output logic                             match,
  output logic                             no_ref,
  output logic [ROWS-1:0]                  row_mismatch,
  output logic [COLS-1:0]                  col_mismatch,
  output logic [total_w(ROWS, COLS)-1:0]   ones_count
);

  localparam int RSUM_W = row_sum_w(COLS);
  localparam int CSUM_W = col_sum_w(ROWS);
  localparam int TOT_W  = total_w(ROWS, COLS);
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  chk_state_t          r_state;
  chk_state_t          w_state_nxt;

  logic [COLS-1:0]     r_snap    [ROWS];
  logic                r_mode;
  logic [RIDX_W-1:0]   r_row_idx;
  logic [RSUM_W-1:0]   r_row_sum [ROWS];
  logic [CSUM_W-1:0]   r_col_sum [COLS];
  logic [RSUM_W-1:0]   r_ref_row [ROWS];
  logic [CSUM_W-1:0]   r_ref_col [COLS];
  logic                r_ref_valid;

  logic                r_busy;
  logic                r_done;
  logic                r_match;
  logic                r_no_ref;
  logic [ROWS-1:0]     r_row_mis;
  logic [COLS-1:0]     r_col_mis;
  logic [TOT_W-1:0]    r_ones;

  logic                w_accept;
  logic                w_last_row;
  logic [COLS-1:0]     w_row;
  logic [RSUM_W-1:0]   w_pop;
  logic [ROWS-1:0]     w_row_diff;
  logic [COLS-1:0]     w_col_diff;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last_row = (r_row_idx == RIDX_W'(ROWS - 1));
  assign w_row      = r_snap[r_row_idx];

  rect_row_popcount #(.W(COLS)) u_row_pop (
    .i_vec   (w_row),
    .o_count (w_pop)
  );

  always_comb begin
    w_row_diff = '0;
    w_col_diff = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_row_diff[r] = (r_row_sum[r] != r_ref_row[r]);
    end
    for (int c = 0; c < COLS; c++) begin
      w_col_diff[c] = (r_col_sum[c] != r_ref_col[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = SCAN;
      SCAN:    if (w_last_row) w_state_nxt = COMPARE;
      COMPARE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= MODE_CAPTURE;
      r_row_idx   <= '0;
      r_ref_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_match     <= 1'b0;
      r_no_ref    <= 1'b0;
      r_row_mis   <= '0;
      r_col_mis   <= '0;
      r_ones      <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_snap[r]    <= '0;
        r_row_sum[r] <= '0;
        r_ref_row[r] <= '0;
      end
      for (int c = 0; c < COLS; c++) begin
        r_col_sum[c] <= '0;
        r_ref_col[c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      // Busy covers the done cycle too, which is spent back in IDLE.
      r_busy <= (w_state_nxt != IDLE) || (r_state == COMPARE);

      if (w_accept) begin
        for (int r = 0; r < ROWS; r++) begin
          r_snap[r] <= m_in[r*COLS +: COLS];
        end
        for (int c = 0; c < COLS; c++) begin
          r_col_sum[c] <= '0;
        end
        r_mode    <= mode;
        r_row_idx <= '0;
        r_ones    <= '0;
        r_match   <= 1'b0;
        r_no_ref  <= 1'b0;
        r_row_mis <= '0;
        r_col_mis <= '0;
      end

      if (r_state == SCAN) begin
        r_row_sum[r_row_idx] <= w_pop;
        r_ones               <= r_ones + TOT_W'(w_pop);
        for (int c = 0; c < COLS; c++) begin
          r_col_sum[c] <= r_col_sum[c] + CSUM_W'(w_row[c]);
        end
        r_row_idx <= w_last_row ? '0 : r_row_idx + RIDX_W'(1);
      end

      if (r_state == COMPARE) begin
        r_done <= 1'b1;
        if (r_mode == MODE_CAPTURE) begin
          for (int r = 0; r < ROWS; r++) r_ref_row[r] <= r_row_sum[r];
          for (int c = 0; c < COLS; c++) r_ref_col[c] <= r_col_sum[c];
          r_ref_valid <= 1'b1;
          r_match     <= 1'b1;
          r_no_ref    <= 1'b0;
          r_row_mis   <= '0;
          r_col_mis   <= '0;
        end else if (r_ref_valid) begin
          r_row_mis <= w_row_diff;
          r_col_mis <= w_col_diff;
          r_match   <= ~(|w_row_diff) & ~(|w_col_diff);
          r_no_ref  <= 1'b0;
        end else begin
          // Check without a reference: flag it and leave the reference alone.
          r_match   <= 1'b0;
          r_no_ref  <= 1'b1;
          r_row_mis <= '0;
          r_col_mis <= '0;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign match        = r_match;
  assign no_ref       = r_no_ref;
  assign row_mismatch = r_row_mis;
  assign col_mismatch = r_col_mis;
  assign ones_count   = r_ones;

endmodule

// File: tb/tb_rect_margin_checker.sv
// Bench for rect_margin_checker (ROWS=COLS=4): directed scans checked each
// cycle against a behavioural margin model, plus literal expectations.
module tb_rect_margin_checker;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;
  localparam int TW   = $clog2(N + 1);

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            mode;
  logic [N-1:0]    m_in;
  logic            busy;
  logic            done;
  logic            match;
  logic            no_ref;
  logic [ROWS-1:0] row_mismatch;
  logic [COLS-1:0] col_mismatch;
  logic [TW-1:0]   ones_count;

  rect_margin_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .m_in         (m_in),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .no_ref       (no_ref),
    .row_mismatch (row_mismatch),
    .col_mismatch (col_mismatch),
    .ones_count   (ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: -1 when no scan is in flight, else edges since acceptance.
  int              m_phase   = -1;
  bit              ref_valid = 1'b0;
  int              ref_row [ROWS];
  int              ref_col [COLS];
  int              s_row [ROWS];
  int              s_col [COLS];
  bit              s_mode;
  bit              mdl_idle;
  bit              exp_busy  = 1'b0;
  bit              exp_done  = 1'b0;
  bit              exp_match = 1'b0;
  bit              exp_noref = 1'b0;
  logic [ROWS-1:0] exp_rm    = '0;
  logic [COLS-1:0] exp_cm    = '0;
  int              exp_ones  = 0;

  task automatic finish_scan();
    exp_rm = '0;
    exp_cm = '0;
    if (s_mode == 1'b0) begin
      for (int r = 0; r < ROWS; r++) ref_row[r] = s_row[r];
      for (int c = 0; c < COLS; c++) ref_col[c] = s_col[c];
      ref_valid = 1'b1;
      exp_match = 1'b1;
      exp_noref = 1'b0;
    end else if (ref_valid) begin
      for (int r = 0; r < ROWS; r++) exp_rm[r] = (s_row[r] != ref_row[r]);
      for (int c = 0; c < COLS; c++) exp_cm[c] = (s_col[c] != ref_col[c]);
      exp_match = (exp_rm == '0) && (exp_cm == '0);
      exp_noref = 1'b0;
    end else begin
      exp_match = 1'b0;
      exp_noref = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   = -1;
      ref_valid = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_match = 1'b0;
      exp_noref = 1'b0;
      exp_rm    = '0;
      exp_cm    = '0;
      exp_ones  = 0;
    end else begin
      mdl_idle = (m_phase < 0) || (m_phase == ROWS + 1);
      exp_done = 1'b0;
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase >= 1 && m_phase <= ROWS) exp_ones += s_row[m_phase-1];
        if (m_phase == ROWS + 1) begin
          exp_done = 1'b1;
          finish_scan();
        end
        if (m_phase == ROWS + 2) m_phase = -1;
      end
      if (mdl_idle && start) begin
        for (int c = 0; c < COLS; c++) s_col[c] = 0;
        for (int r = 0; r < ROWS; r++) begin
          s_row[r] = 0;
          for (int c = 0; c < COLS; c++) begin
            s_row[r] += int'(m_in[r*COLS+c]);
            s_col[c] += int'(m_in[r*COLS+c]);
          end
        end
        s_mode    = mode;
        m_phase   = 0;
        exp_match = 1'b0;
        exp_noref = 1'b0;
        exp_rm    = '0;
        exp_cm    = '0;
        exp_ones  = 0;
      end
      exp_busy = (m_phase >= 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy",         busy,         exp_busy);
      chk("done",         done,         exp_done);
      chk("match",        match,        exp_match);
      chk("no_ref",       no_ref,       exp_noref);
      chk("row_mismatch", row_mismatch, exp_rm);
      chk("col_mismatch", col_mismatch, exp_cm);
      chk("ones_count",   ones_count,   exp_ones);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_scan(input bit md, input logic [N-1:0] m, output int lat);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    m_in  = m;
    @(negedge clk);
    start = 1'b0;
    m_in  = N'($urandom);
    cyc   = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) chk("done_timeout", 32'(cyc), 32'(ROWS + 1));
    lat = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   busy,         0);
    chk({tag, "_done"},   done,         0);
    chk({tag, "_match"},  match,        0);
    chk({tag, "_no_ref"}, no_ref,       0);
    chk({tag, "_rm"},     row_mismatch, 0);
    chk({tag, "_cm"},     col_mismatch, 0);
    chk({tag, "_ones"},   ones_count,   0);
  endtask

  initial begin
    int lat;
    int ndone;
    int done_k;
    bit got_match;
    start = 1'b0;
    mode  = 1'b0;
    m_in  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Check with no reference captured yet.
    run_scan(1'b1, 16'h1234, lat);
    chk("noref_match", match, 0);
    chk("noref_flag", no_ref, 1);
    chk("noref_rm", row_mismatch, 0);

    // Capture 0F0F: rows 4,0,4,0; cols 2,2,2,2.
    run_scan(1'b0, 16'h0F0F, lat);
    chk("cap_latency", lat, 5);
    chk("cap_match", match, 1);
    chk("cap_no_ref_cleared", no_ref, 0);
    chk("cap_ones", ones_count, 8);
    chk("ref_row0", ref_row[0], 4);
    chk("ref_row1", ref_row[1], 0);
    chk("ref_row2", ref_row[2], 4);
    chk("ref_row3", ref_row[3], 0);
    for (int c = 0; c < COLS; c++) chk("ref_col", ref_col[c], 2);

    // Broken margin: row0/col0 lose a one.
    run_scan(1'b1, 16'h0F0E, lat);
    chk("brk_match", match, 0);
    chk("brk_rm", row_mismatch, 4'b0001);
    chk("brk_cm", col_mismatch, 4'b0001);
    chk("brk_ones", ones_count, 7);

    // Checkerboard swap keeps margins.
    run_scan(1'b0, 16'h0012, lat);
    run_scan(1'b1, 16'h0021, lat);
    chk("swap_match", match, 1);
    chk("swap_rm", row_mismatch, 0);
    chk("swap_cm", col_mismatch, 0);
    chk("swap_ones", ones_count, 2);

    // Start while busy is ignored; m_in changes after acceptance are ignored.
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    m_in  = 16'h0021;
    ndone = 0;
    done_k = -1;
    got_match = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k == 1) || (k == ROWS);
      if (k == 0) m_in = 16'hFFFF;
      if (k == 2) m_in = 16'h1234;
      if (done === 1'b1) begin
        ndone++;
        done_k = k;
        got_match = match;
      end
    end
    start = 1'b0;
    chk("busy_done_count", ndone, 1);
    chk("busy_done_edge", done_k, ROWS + 1);
    chk("busy_match", got_match, 1);

    // Full / empty matrix boundaries.
    run_scan(1'b0, 16'hFFFF, lat);
    chk("full_ones", ones_count, 16);
    run_scan(1'b1, 16'h0000, lat);
    chk("empty_match", match, 0);
    chk("empty_rm", row_mismatch, 4'hF);
    chk("empty_cm", col_mismatch, 4'hF);
    chk("empty_ones", ones_count, 0);

    // Reset in the middle of a capture.
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    m_in  = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b1, 16'h00FF, lat);
    chk("midrst_no_ref", no_ref, 1);
    chk("midrst_match", match, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
